sdram_arbiter: RTL and testbench

// Shares the single-port SDRAM controller between several requesters:
// - the ROM download writer
// - NUM_PORTS game ROM read ports (CPU, tile, sprite, sound)

---
 rtl/sdram_arbiter_pkg.sv | 14 +
 rtl/sdram_arbiter_rr_select.sv | 35 +++
 rtl/sdram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sdram_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM arbiter types and widths.
// Used by the arbiter, the SDRAM controller and the ROM loaders.
package sdram_arbiter_pkg;

  localparam int SDRAM_AW = 23;
  localparam int SDRAM_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arb_state_e;

endpackage

// File: rtl/sdram_arbiter_rr_select.sv
// Combinational round-robin picker.
// Grants the first set request at or after ptr_i, wrapping at N.
module rr_select
  import sdram_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Walk from the farthest offset down so the nearest one wins.
  always_comb begin
    logic [IW:0] p;
    p     = '0;
    gnt_o = '0;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      p = {1'b0, ptr_i} + (IW+1)'(k);
      if (p >= (IW+1)'(N)) p = p - (IW+1)'(N);
      if (req_i[p[IW-1:0]]) begin
        gnt_o             = '0;
        gnt_o[p[IW-1:0]]  = 1'b1;
        idx_o             = p[IW-1:0];
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/sdram_arbiter.sv
// Single-outstanding SDRAM arbiter: download writes first,
// game ROM reads round-robin, with a read-data timeout.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = SDRAM_AW,
  parameter int DATA_WIDTH = SDRAM_DW,
  parameter int TIMEOUT    = 255
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [ADDR_WIDTH-1:0]           dl_addr,
  input  logic [DATA_WIDTH-1:0]           dl_data,
  input  logic                            dl_req,
  output logic                            dl_ack,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rom_addr,
  input  logic [NUM_PORTS-1:0]            rom_req,
  output logic [NUM_PORTS-1:0]            rom_ack,
  output logic [NUM_PORTS-1:0]            rom_valid,
  output logic [DATA_WIDTH-1:0]           rom_data,
  output logic [ADDR_WIDTH-1:0]           sdram_addr,
  output logic [DATA_WIDTH-1:0]           sdram_data,
  output logic                            sdram_we,
  output logic                            sdram_req,
  input  logic                            sdram_ack,
  input  logic                            sdram_valid,
  input  logic [DATA_WIDTH-1:0]           sdram_q,
  output logic                            timeout_err
);

  localparam int IW = $clog2(NUM_PORTS);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]         gnt_idx_q, gnt_idx_d;
  logic [NUM_PORTS-1:0]  gnt_oh_q, gnt_oh_d;
  logic                  wr_q, wr_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [7:0]            timer_q, timer_d;
  logic [NUM_PORTS-1:0]  valid_q, valid_d;
  logic                  tmo_q, tmo_d;

  logic [NUM_PORTS-1:0]  sel_gnt;
  logic [IW-1:0]         sel_idx;
  logic                  sel_any;
  logic                  acked;

  rr_select #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_rr (
    .req_i (rom_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (sel_gnt),
    .idx_o (sel_idx),
    .any_o (sel_any)
  );

  // Acks are combinational so the requester can drop req before the next grant.
  assign acked = reset_n && req_q && sdram_ack && (state_q == REQ);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_oh_d  = gnt_oh_q;
    wr_d      = wr_q;
    req_d     = req_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rdata_d   = rdata_q;
    timer_d   = timer_q;
    valid_d   = '0;
    tmo_d     = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (dl_req) begin
          wr_d     = 1'b1;
          req_d    = 1'b1;
          addr_d   = dl_addr;
          data_d   = dl_data;
          gnt_oh_d = '0;
          state_d  = REQ;
        end else if (sel_any) begin
          wr_d      = 1'b0;
          req_d     = 1'b1;
          addr_d    = rom_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
          gnt_idx_d = sel_idx;
          gnt_oh_d  = sel_gnt;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (acked) begin
          req_d = 1'b0;
          if (wr_q) begin
            state_d = IDLE;
          end else begin
            if (gnt_idx_q == IW'(NUM_PORTS - 1)) rr_ptr_d = '0;
            else rr_ptr_d = gnt_idx_q + IW'(1);
            timer_d = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        timer_d = timer_q + 8'd1;
        if (sdram_valid) begin
          valid_d = gnt_oh_q;
          rdata_d = sdram_q;
          state_d = IDLE;
        end else if (timer_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      wr_q      <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      timer_q   <= '0;
      valid_q   <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_oh_q  <= gnt_oh_d;
      wr_q      <= wr_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rdata_q   <= rdata_d;
      timer_q   <= timer_d;
      valid_q   <= valid_d;
      tmo_q     <= tmo_d;
    end
  end

  assign dl_ack      = acked && wr_q;
  assign rom_ack     = (acked && !wr_q) ? gnt_oh_q : '0;
  assign rom_valid   = valid_q;
  assign rom_data    = rdata_q;
  assign sdram_addr  = addr_q;
  assign sdram_data  = data_q;
  assign sdram_we    = wr_q;
  assign sdram_req   = req_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a behavioural controller,
// level-hold requesters and an issue/data scoreboard.
module tb_sdram_arbiter;

  localparam int NP  = 4;
  localparam int AW  = 23;
  localparam int DW  = 32;
  localparam int TMO = 255;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            port;
  } iss_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } val_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [AW-1:0]    dl_addr;
  logic [DW-1:0]    dl_data;
  logic             dl_req;
  logic             dl_ack;
  logic [NP*AW-1:0] rom_addr;
  logic [NP-1:0]    rom_req;
  logic [NP-1:0]    rom_ack;
  logic [NP-1:0]    rom_valid;
  logic [DW-1:0]    rom_data;
  logic [AW-1:0]    sdram_addr;
  logic [DW-1:0]    sdram_data;
  logic             sdram_we;
  logic             sdram_req;
  logic             sdram_ack;
  logic             sdram_valid;
  logic [DW-1:0]    sdram_q;
  logic             timeout_err;

  sdram_arbiter #(
    .NUM_PORTS  (NP),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .dl_req      (dl_req),
    .dl_ack      (dl_ack),
    .rom_addr    (rom_addr),
    .rom_req     (rom_req),
    .rom_ack     (rom_ack),
    .rom_valid   (rom_valid),
    .rom_data    (rom_data),
    .sdram_addr  (sdram_addr),
    .sdram_data  (sdram_data),
    .sdram_we    (sdram_we),
    .sdram_req   (sdram_req),
    .sdram_ack   (sdram_ack),
    .sdram_valid (sdram_valid),
    .sdram_q     (sdram_q),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  iss_t          iss_q[$];
  val_t          val_q[$];
  int            pend[NP];
  int            dl_pend = 0;
  logic          req_prev = 1'b0;
  logic [NP:0]   exp_ack = '0;
  int            ack_cyc = 0;
  int            cst = 0;
  int            cnt = 0;
  int            ack_dly = 1;
  int            val_dly = 1;
  bit            give_valid = 1'b1;
  int            stray_n = 0;
  logic [AW-1:0] c_addr = '0;
  int            vcyc = 0;
  int            n;

  function automatic logic [DW-1:0] q_of(input logic [AW-1:0] a);
    if (a == 23'h1234) return 32'hDEADBEEF;
    return {9'h0, a} ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic ctrl_step();
    sdram_ack   = 1'b0;
    sdram_valid = 1'b0;
    if (!reset_n) begin
      cst = 0;
    end else begin
      case (cst)
        0: if (sdram_req) begin cst = 1; cnt = ack_dly; end
        1: begin
          cnt--;
          if (cnt <= 0) begin
            sdram_ack = 1'b1;
            c_addr    = sdram_addr;
            cst       = (!sdram_we && give_valid) ? 2 : 0;
            cnt       = val_dly;
          end
        end
        2: begin
          cnt--;
          if (cnt <= 0) begin
            sdram_valid = 1'b1;
            sdram_q     = q_of(c_addr);
            vcyc        = cyc + 1;
            cst         = 0;
          end
        end
        default: cst = 0;
      endcase
      if (stray_n > 0 && cst == 0 && !sdram_valid) begin
        sdram_valid = 1'b1;
        sdram_q     = 32'h0BADF00D;
        stray_n--;
      end
    end
  endtask

  task automatic mon_step();
    iss_t          it;
    val_t          v;
    logic [NP-1:0] oh;
    if (sdram_req && !req_prev) begin
      checks++;
      assert (iss_q.size() != 0) else begin
        errors++;
        $error("FAIL unexp_req obs=%0h exp=none", sdram_addr);
      end
      if (iss_q.size() != 0) begin
        it = iss_q.pop_front();
        chk("req_we", 64'(sdram_we), 64'(it.we));
        chk("req_addr", 64'(sdram_addr), 64'(it.addr));
        if (it.we) chk("req_data", 64'(sdram_data), 64'(it.data));
        oh = '0;
        if (!it.we) oh[it.port] = 1'b1;
        exp_ack = {it.we, oh};
      end
    end
    req_prev = sdram_req;
    if (dl_ack || rom_ack != '0) begin
      chk("ack", 64'({dl_ack, rom_ack}), 64'(exp_ack));
      exp_ack = '0;
      ack_cyc = cyc;
      if (dl_ack && dl_pend > 0) begin
        dl_pend--;
        if (dl_pend == 0) dl_req = 1'b0;
      end
      for (int i = 0; i < NP; i++) begin
        if (rom_ack[i] && pend[i] > 0) begin
          pend[i]--;
          if (pend[i] == 0) rom_req[i] = 1'b0;
        end
      end
    end
    if (rom_valid != '0) begin
      checks++;
      assert (val_q.size() != 0) else begin
        errors++;
        $error("FAIL stray_valid obs=%0h exp=0", rom_valid);
      end
      if (val_q.size() != 0) begin
        v  = val_q.pop_front();
        oh = '0;
        oh[v.port] = 1'b1;
        chk("valid_port", 64'(rom_valid), 64'(oh));
        chk("rom_data", 64'(rom_data), 64'(v.data));
        chk("valid_lat", 64'(cyc), 64'(vcyc));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    ctrl_step();
    #1;
    mon_step();
  endtask

  task automatic exp_rd(input int p);
    logic [AW-1:0] a;
    a = rom_addr[p*AW +: AW];
    iss_q.push_back('{we: 1'b0, addr: a, data: '0, port: p});
    val_q.push_back('{port: p, data: q_of(a)});
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while ((iss_q.size() != 0 || val_q.size() != 0 || rom_req != '0 ||
            dl_req || cst != 0) && k < budget) begin
      tick();
      k++;
    end
    checks++;
    assert (k < budget) else begin
      errors++;
      $error("FAIL %s obs=%0d cycles exp=<%0d", tag, k, budget);
    end
    tick();
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    dl_addr     = '0;
    dl_data     = '0;
    dl_req      = 1'b0;
    rom_req     = '0;
    sdram_ack   = 1'b0;
    sdram_valid = 1'b0;
    sdram_q     = '0;
    for (int i = 0; i < NP; i++) begin
      pend[i] = 0;
      rom_addr[i*AW +: AW] = 23'h100 + AW'(i * 17);
    end

    do_reset();
    chk("rst_ctl", 64'({sdram_req, sdram_we, dl_ack, rom_ack,
                        rom_valid, timeout_err}), 64'(0));
    chk("rst_addr", 64'(sdram_addr), 64'(0));
    chk("rst_data", 64'(sdram_data), 64'(0));
    chk("rst_rdata", 64'(rom_data), 64'(0));

    // single read on port 2
    rom_addr[2*AW +: AW] = 23'h1234;
    ack_dly = 3;
    val_dly = 5;
    exp_rd(2);
    pend[2]    = 1;
    rom_req[2] = 1'b1;
    wait_done("t1_done", 100);
    rom_addr[2*AW +: AW] = 23'h122;

    // round robin with all ports held for two grants each
    do_reset();
    ack_dly = 2;
    val_dly = 3;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) exp_rd(p);
    for (int p = 0; p < NP; p++) pend[p] = 2;
    rom_req = '1;
    wait_done("t2_done", 300);

    // download beats simultaneous reads; pointer must stay at 0
    ack_dly = 1;
    val_dly = 2;
    dl_addr = 23'h10;
    dl_data = 32'hA5A5A5A5;
    iss_q.push_back('{we: 1'b1, addr: 23'h10, data: 32'hA5A5A5A5,
                      port: -1});
    exp_rd(0);
    exp_rd(1);
    dl_pend = 1;
    pend[0] = 1;
    pend[1] = 1;
    dl_req  = 1'b1;
    rom_req = 4'b0011;
    wait_done("t3_done", 100);

    // read that never returns data
    ack_dly    = 2;
    give_valid = 1'b0;
    iss_q.push_back('{we: 1'b0, addr: rom_addr[1*AW +: AW], data: '0,
                      port: 1});
    pend[1]    = 1;
    rom_req[1] = 1'b1;
    n = 0;
    while (pend[1] != 0 && n < 50) begin tick(); n++; end
    chk("t4_ack_seen", 64'(pend[1]), 64'(0));
    while (cyc < ack_cyc + TMO) tick();
    chk("t4_tmo_early", 64'(timeout_err), 64'(0));
    tick();
    chk("t4_tmo_set", 64'(timeout_err), 64'(1));
    chk("t4_req_idle", 64'(sdram_req), 64'(0));
    give_valid = 1'b1;
    exp_rd(3);
    pend[3]    = 1;
    rom_req[3] = 1'b1;
    wait_done("t4_next", 100);
    chk("t4_tmo_sticky", 64'(timeout_err), 64'(1));

    // reset in the middle of a read wait
    give_valid = 1'b0;
    iss_q.push_back('{we: 1'b0, addr: rom_addr[0 +: AW], data: '0,
                      port: 0});
    pend[0]    = 1;
    rom_req[0] = 1'b1;
    n = 0;
    while (pend[0] != 0 && n < 50) begin tick(); n++; end
    chk("t5_ack_seen", 64'(pend[0]), 64'(0));
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    chk("t5_rst_ctl", 64'({sdram_req, sdram_we, dl_ack, rom_ack,
                           rom_valid, timeout_err}), 64'(0));
    chk("t5_rst_rdata", 64'(rom_data), 64'(0));
    chk("t5_rst_addr", 64'(sdram_addr), 64'(0));
    reset_n    = 1'b1;
    give_valid = 1'b1;
    stray_n    = 1;
    tick();
    tick();
    chk("t5_stray", 64'(rom_valid), 64'(0));

    // stray valid in idle, then a fresh pair of reads from pointer 0
    stray_n = 1;
    tick();
    tick();
    chk("t6_stray", 64'(rom_valid), 64'(0));
    chk("t6_idle", 64'(sdram_req), 64'(0));
    exp_rd(0);
    exp_rd(3);
    pend[0] = 1;
    pend[3] = 1;
    rom_req = 4'b1001;
    wait_done("t6_done", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
